// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer: FIFO-buffered set/clear/toggle front-end for an SR flop bank; SR_REDUNDANT_SUPPRESS_EN drops redundant commands
module sr_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic [1:0]               req_op,
  output logic                     req_ready,
  output logic [1:0]               sr,
  output logic                     busy,
  output logic                     q_mirror,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE} state_t;
  state_t state;
  logic [1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0] hold_cnt;
  logic full, empty, push, pop, drop;
  logic [1:0] head, code;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign req_ready = !full;
  assign fifo_count = wr_ptr - rd_ptr;
  assign push = req_valid && !full && req_op != 2'b00;
  assign pop = state == IDLE && !empty;
  assign busy = state != IDLE || !empty;
  assign head = mem[rd_ptr[AW-1:0]];
  assign code = head == 2'b01 ? 2'b01 : head == 2'b10 ? 2'b10 : (q_mirror ? 2'b01 : 2'b10);
`ifdef SR_REDUNDANT_SUPPRESS_EN
  assign drop = head != 2'b11 && code[1] == q_mirror;
`else
  assign drop = 1'b0;
`endif
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= req_op;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sr <= 2'b00;
      q_mirror <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      case (state)
        IDLE:
          if (pop && !drop) begin
            sr <= code;
            q_mirror <= code[1];
            hold_cnt <= 8'(HOLD_CYCLES - 1);
            state <= DRIVE;
          end else sr <= 2'b00;
        DRIVE:
          if (hold_cnt == 8'd0) begin
            sr <= 2'b00;
            state <= SETTLE;
          end else hold_cnt <= hold_cnt - 8'd1;
        SETTLE: state <= IDLE;
        default: begin
          state <= IDLE;
          sr <= 2'b00;
        end
      endcase
    end
  end
endmodule
